// File: rtl/demux_pkg.sv
// Shared constants for the 1:4 byte demultiplexer and its channel FIFOs.
package demux_pkg;

   localparam int CHAN_N = 4;
   localparam int SEL_W  = 2;

   typedef enum logic [SEL_W-1:0] {
      CH_RF    = 2'd0,
      CH_DMEM  = 2'd1,
      CH_IO    = 2'd2,
      CH_SPARE = 2'd3
   } chan_e;

endpackage

// File: rtl/demux_chan_fifo.sv
// Per-channel FIFO: registered full/empty, head always presented on data_out.
module demux_chan_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] data_in,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] data_out,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign data_out = mem[rd_ptr];

   // Storage is cleared too, so the head reads zero straight out of reset.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= data_in;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (!do_push && do_pop) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/demux_buf.sv
// Steers one byte stream to four independently buffered consumer channels.
module demux_buf
   import demux_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_data,
   input  logic [SEL_W-1:0]      in_sel,
   output logic [CHAN_N-1:0]     out_valid,
   input  logic [CHAN_N-1:0]     out_ready,
   output logic [CHAN_N*WIDTH-1:0] out_data,
   output logic [7:0]            xfer_cnt
);

   logic [CHAN_N-1:0] full;
   logic [CHAN_N-1:0] empty;
   logic [CHAN_N-1:0] push;
   logic              accept;

   // Ready comes only from registered full flags: no ready->ready path.
   assign in_ready  = !full[in_sel];
   assign accept    = in_valid && in_ready;
   assign out_valid = ~empty;

   always_comb begin
      push = '0;
      for (int unsigned k = 0; k < CHAN_N; k++) begin
         push[k] = accept && (in_sel == SEL_W'(k));
      end
   end

   for (genvar k = 0; k < CHAN_N; k++) begin : g_chan
      demux_chan_fifo #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH)
      ) u_fifo (
         .Clk      (Clk),
         .Reset_n  (Reset_n),
         .push     (push[k]),
         .data_in  (in_data),
         .full     (full[k]),
         .pop      (out_ready[k]),
         .data_out (out_data[k*WIDTH +: WIDTH]),
         .empty    (empty[k])
      );
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         xfer_cnt <= '0;
      end else if (accept) begin
         xfer_cnt <= xfer_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_demux_buf.sv
// Directed bench for demux_buf: routing table plus multi-cycle corner sequences.
module tb_demux_buf;

   logic        Clk;
   logic        Reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic [1:0]  in_sel;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [31:0] out_data;
   logic [7:0]  xfer_cnt;

   int total;
   int bad;

   demux_buf #(
      .WIDTH (8),
      .DEPTH (2)
   ) dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .xfer_cnt  (xfer_cnt)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // in_sel must not move while a stalled offer is pending.
   logic       pv;
   logic       pr;
   logic [1:0] ps;
   initial begin
      pv = 1'b0;
      pr = 1'b1;
      ps = 2'd0;
   end
   always @(posedge Clk) begin
      if (Reset_n && pv && !pr && in_valid)
         assert (in_sel == ps) else $error("protocol: in_sel changed while stalled");
      pv <= in_valid;
      pr <= in_ready;
      ps <= in_sel;
   end

   typedef struct {
      logic       iv;
      logic [1:0] sel;
      logic [7:0] din;
      logic [3:0] ordy;
      logic       exp_rdy;
      logic [3:0] exp_ov;
      logic [7:0] exp_cnt;
      logic [7:0] exp_dat;
   } vec_t;

   vec_t tbl[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   function automatic logic [7:0] chan(input int k);
      logic [31:0] d;
      d = out_data;
      return d[k*8 +: 8];
   endfunction

   task automatic pulse_reset();
      #2 Reset_n = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_xfer_cnt", 32'(xfer_cnt), 32'h0);
      chk("rst_out_data", out_data, 32'h0);
      #2 Reset_n = 1'b1;
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      Reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      in_sel    = 2'd0;
      out_ready = 4'b0000;

      tbl[0] = '{1'b1, 2'd0, 8'hA0, 4'b1111, 1'b1, 4'b0001, 8'd1, 8'hA0};
      tbl[1] = '{1'b1, 2'd1, 8'hA1, 4'b1111, 1'b1, 4'b0010, 8'd2, 8'hA1};
      tbl[2] = '{1'b1, 2'd2, 8'hA2, 4'b1111, 1'b1, 4'b0100, 8'd3, 8'hA2};
      tbl[3] = '{1'b1, 2'd3, 8'hA3, 4'b1111, 1'b1, 4'b1000, 8'd4, 8'hA3};
      tbl[4] = '{1'b0, 2'd3, 8'h00, 4'b1111, 1'b1, 4'b0000, 8'd4, 8'h00};

      #12;
      chk("init_out_valid", 32'(out_valid), 32'h0);
      chk("init_out_data", out_data, 32'h0);
      chk("init_xfer_cnt", 32'(xfer_cnt), 32'h0);
      Reset_n = 1'b1;
      step();

      // Reset mid-traffic
      in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h11;
      step();
      in_data = 8'h22;
      step();
      in_valid = 1'b0;
      chk("pre_rst_valid", 32'(out_valid), 32'h4);
      chk("pre_rst_cnt", 32'(xfer_cnt), 32'd2);
      pulse_reset();
      for (int s = 0; s < 4; s++) begin
         in_sel = 2'(s);
         #1;
         chk("post_rst_ready", 32'(in_ready), 32'h1);
      end
      step();

      // Basic routing table
      for (int i = 0; i < 5; i++) begin
         in_valid  = tbl[i].iv;
         in_sel    = tbl[i].sel;
         in_data   = tbl[i].din;
         out_ready = tbl[i].ordy;
         #1;
         chk("tbl_in_ready", 32'(in_ready), 32'(tbl[i].exp_rdy));
         step();
         chk("tbl_out_valid", 32'(out_valid), 32'(tbl[i].exp_ov));
         chk("tbl_xfer_cnt", 32'(xfer_cnt), 32'(tbl[i].exp_cnt));
         if (tbl[i].exp_ov[tbl[i].sel])
            chk("tbl_out_data", 32'(chan(int'(tbl[i].sel))), 32'(tbl[i].exp_dat));
      end

      // Full and backpressure on channel 1
      out_ready = 4'b0000;
      in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h10;
      step();
      in_data = 8'h20;
      step();
      chk("bp_head_10", 32'(chan(1)), 32'h10);
      in_data = 8'h30;
      #1;
      chk("bp_full_ready", 32'(in_ready), 32'h0);
      out_ready = 4'b0010;
      #1;
      chk("bp_ready_with_pop", 32'(in_ready), 32'h0);
      step();
      out_ready = 4'b0000;
      chk("bp_head_20", 32'(chan(1)), 32'h20);
      chk("bp_not_accepted", 32'(xfer_cnt), 32'd6);
      chk("bp_ready_again", 32'(in_ready), 32'h1);
      step();
      in_valid = 1'b0;
      chk("bp_accepted", 32'(xfer_cnt), 32'd7);
      chk("bp_head_still_20", 32'(chan(1)), 32'h20);
      out_ready = 4'b0010;
      step();
      chk("bp_head_30_valid", 32'(out_valid), 32'h2);
      chk("bp_head_30", 32'(chan(1)), 32'h30);
      step();
      out_ready = 4'b0000;
      chk("bp_drained", 32'(out_valid), 32'h0);

      // Head-of-line isolation
      in_valid = 1'b1; in_sel = 2'd3; in_data = 8'hE1;
      step();
      in_data = 8'hE2;
      step();
      #1;
      chk("hol_ch3_full", 32'(in_ready), 32'h0);
      in_valid = 1'b0;
      #1 in_sel = 2'd0;
      #1;
      chk("hol_ch0_ready", 32'(in_ready), 32'h1);
      in_valid = 1'b1; in_data = 8'h55;
      step();
      in_valid = 1'b0;
      chk("hol_valid", 32'(out_valid), 32'h9);
      chk("hol_ch0_data", 32'(chan(0)), 32'h55);
      chk("hol_ch3_data", 32'(chan(3)), 32'hE1);
      out_ready = 4'b1111;
      step();
      chk("hol_ch3_second", 32'(chan(3)), 32'hE2);
      chk("hol_valid2", 32'(out_valid), 32'h8);
      step();
      out_ready = 4'b0000;
      chk("hol_drained", 32'(out_valid), 32'h0);

      // Wrap and counter: 300 bytes, push and pop every cycle
      pulse_reset();
      step();
      out_ready = 4'b0100;
      in_valid  = 1'b1;
      in_sel    = 2'd2;
      for (int i = 0; i < 300; i++) begin
         in_data = 8'(i);
         #1;
         chk("wrap_ready", 32'(in_ready), 32'h1);
         step();
         chk("wrap_valid", 32'(out_valid), 32'h4);
         chk("wrap_data", 32'(chan(2)), 32'(i % 256));
      end
      in_valid = 1'b0;
      step();
      out_ready = 4'b0000;
      chk("wrap_empty", 32'(out_valid), 32'h0);
      chk("wrap_xfer_cnt", 32'(xfer_cnt), 32'd44);

      // Concurrent pops
      in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_sel  = 2'(k);
         in_data = 8'(8'hC0 + k);
         step();
      end
      in_valid = 1'b0;
      chk("cc_all_valid", 32'(out_valid), 32'hF);
      chk("cc_all_data", out_data, 32'hC3C2C1C0);
      out_ready = 4'b1111;
      step();
      out_ready = 4'b0000;
      chk("cc_all_popped", 32'(out_valid), 32'h0);
      chk("cc_xfer_cnt", 32'(xfer_cnt), 32'd48);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/demux_buf.md
Name: demux_buf

Overview:
- Inverse of the datapath's 4:1 byte select: one 8-bit producer stream is steered, by a 2-bit select, to one of four consumer channels.
- Each channel has its own small FIFO with a valid/ready handshake, so consumers can stall independently.
- Sits between the result/writeback source and the four destination ports (register file, data memory, I/O, spare).

Parameters:
- WIDTH, 8, data width of every channel.
- DEPTH, 2, entries per channel FIFO; power of two, ≥2.

Ports:
- Clk  input  1  single clock, rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer offers in_data this cycle.
- in_ready  output  1  selected channel can accept; combinational.
- in_data  input  WIDTH  byte to route.
- in_sel  input  2  destination channel 0..3; must be held stable while in_valid is high.
- out_valid  output  4  bit k: channel k head entry valid.
- out_ready  input  4  bit k: consumer k takes the head.
- out_data  output  4*WIDTH  channel k head at [k*WIDTH +: WIDTH].
- xfer_cnt  output  8  accepted-input count, wraps 255->0.

Behaviour:
- Reset and clock: one clock; reset is asynchronous and active-low.
- Reset state, applied immediately on Reset_n low, regardless of any handshake in flight:
  - all FIFO counts and read/write pointers = 0;
  - out_valid = 4'b0000, out_data = 0, xfer_cnt = 0.
  - Entries in flight at reset are discarded.
- Accept (push):
  - in_ready = !full[in_sel], a pure function of in_sel and the registered full flags.
  - Push to channel in_sel happens at the rising edge when in_valid && in_ready.
  - xfer_cnt increments on every push.
- Deliver (pop):
  - Channel k pops at the rising edge when out_valid[k] && out_ready[k].
  - out_data of channel k always shows mem[rd_ptr_k]; its value is don't-care (stale) when out_valid[k] = 0.
- Latency: no bypass. A byte pushed at edge N is visible, with out_valid set, after edge N. Minimum in-to-out latency is 1 cycle.
- Full channel:
  - in_ready = 0 while in_sel points at a full channel, even if that channel pops in the same cycle. There is no same-cycle pass-through, which avoids a ready->ready combinational path.
  - Non-selected channels are unaffected. Head-of-line blocking of the input is intended.
- Empty channel: out_valid[k] = 0; out_ready[k] is ignored and no pointer moves.
- Simultaneous push and pop on the same non-full, non-empty channel: count unchanged, both pointers advance.
- Simultaneous pops on several channels: all are independent and all complete in the same cycle.
- Wrap: rd/wr pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits, range 0..DEPTH.
  - full = (count == DEPTH); empty = (count == 0).
- in_valid low: in_ready still reflects the selected channel, and no push occurs.
- Protocol violation (in_sel changed while in_valid is high and in_ready low): undefined routing. The bench asserts against it; RTL does not check it.

Decomposition:
- Shared package/header (demux_pkg):
  - CHAN_N = 4, SEL_W = 2;
  - channel index constants CH_RF = 0, CH_DMEM = 1, CH_IO = 2, CH_SPARE = 3.
- One sub-module, demux_chan_fifo (WIDTH, DEPTH): push/data_in/full, pop/data_out/empty, with the same Clk/Reset_n.
  - The top instantiates four of these with a generate loop.
  - The top adds only the select decode, the in_ready mux and xfer_cnt.

Test Plan:
- Reset mid-traffic: fill channel 2 with 0x11, 0x22, then pulse Reset_n low between edges.
  - Expect out_valid = 0000 and xfer_cnt = 0 immediately, with no wait for a clock edge.
  - After release, in_ready = 1 for every in_sel.
- Basic routing: out_ready = 1111; push 0xA0, 0xA1, 0xA2, 0xA3 with in_sel = 0, 1, 2, 3 on consecutive cycles.
  - Each byte appears on its channel exactly one cycle after its accept edge.
  - xfer_cnt = 4.
- Full and backpressure: out_ready[1] = 0; push 0x10, 0x20 to channel 1.
  - Third attempt with 0x30: in_ready = 0.
  - Raise out_ready[1] on that cycle: 0x10 pops, 0x30 is still not accepted; it is accepted on the next edge.
  - Order 0x10, 0x20, 0x30 is preserved.
- Head-of-line isolation: channel 3 full with in_sel = 3, so in_ready = 0.
  - Switch in_sel to 0 while in_valid is low, then push 0x55.
  - 0x55 is accepted and appears on channel 0; channel 3 contents are unchanged.
- Wrap and counter: stream 300 bytes (value = i mod 256) to channel 2 with simultaneous push/pop every cycle.
  - All bytes arrive in order and no bubbles follow the first.
  - xfer_cnt = 300 mod 256 = 44.
- Concurrent pops: preload one byte in each channel (0xC0..0xC3), then raise out_ready = 1111 for one cycle.
  - All four pop on the same edge; out_valid = 0000 after it.
